// File: rtl/alu_sequencer.sv
// Issue/writeback sequencer for the simpleCPU ALU: accepts one instruction in IDLE, 1 cycle for
// local ops, 4 cycles for ALU ops; instr_ready drops whenever an op is in flight or the core is halted.
module alu_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       instr_op,
  input  logic [WIDTH-1:0] instr_operand,
  input  logic             resume,
  output logic [1:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_data,
  output logic [WIDTH-1:0] alu_accum,
  output logic             alu_clk,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic [WIDTH-1:0] accum,
  output logic             result_valid,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_WB     = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_INC = 3'b011;
  localparam logic [2:0] OP_DEC = 3'b100;
  localparam logic [2:0] OP_SKZ = 3'b101;
  localparam logic [2:0] OP_HLT = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  state_t state;
  logic   skip_pending;
  logic   accept;

  assign instr_ready = (state == S_IDLE);
  assign alu_accum   = accum;
  assign accept      = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      accum        <= '0;
      alu_opcode   <= 2'b00;
      alu_data     <= '0;
      alu_clk      <= 1'b0;
      result_valid <= 1'b0;
      halted       <= 1'b0;
      illegal      <= 1'b0;
      retired_cnt  <= '0;
      skip_pending <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            // A pending skip swallows whatever arrives next, HLT included.
            if (skip_pending) begin
              skip_pending <= 1'b0;
              retired_cnt  <= retired_cnt + CNT_W'(1);
            end else begin
              case (instr_op)
                OP_LDA: begin
                  accum        <= instr_operand;
                  result_valid <= 1'b1;
                  retired_cnt  <= retired_cnt + CNT_W'(1);
                end
                OP_ADD: begin
                  alu_opcode <= 2'b11;
                  alu_data   <= instr_operand;
                  alu_clk    <= 1'b1;
                  state      <= S_ISSUE;
                end
                OP_INC, OP_DEC: begin
                  alu_opcode <= (instr_op == OP_INC) ? 2'b01 : 2'b10;
                  alu_data   <= '0;
                  alu_clk    <= 1'b1;
                  state      <= S_ISSUE;
                end
                OP_SKZ: begin
                  skip_pending <= alu_zero;
                  retired_cnt  <= retired_cnt + CNT_W'(1);
                end
                OP_HLT: begin
                  halted <= 1'b1;
                  state  <= S_HALTED;
                end
                OP_ILL: begin
                  illegal     <= 1'b1;
                  retired_cnt <= retired_cnt + CNT_W'(1);
                end
                default: begin
                  retired_cnt <= retired_cnt + CNT_W'(1);
                end
              endcase
            end
          end
        end
        // alu_clk was raised on accept, so it is high for exactly the ISSUE cycle.
        S_ISSUE: begin
          alu_clk <= 1'b0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          state <= S_WB;
        end
        S_WB: begin
          accum        <= alu_out;
          result_valid <= 1'b1;
          retired_cnt  <= retired_cnt + CNT_W'(1);
          state        <= S_IDLE;
        end
        S_HALTED: begin
          if (resume) begin
            halted <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU clocked by alu_clk.
`timescale 1ns/1ps
module tb_alu_sequencer;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_INC = 3'b011;
  localparam logic [2:0] OP_DEC = 3'b100;
  localparam logic [2:0] OP_SKZ = 3'b101;
  localparam logic [2:0] OP_HLT = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [2:0]  instr_op = 3'b000;
  logic [7:0]  instr_operand = 8'h00;
  logic        resume = 1'b0;
  logic [1:0]  alu_opcode;
  logic [7:0]  alu_data;
  logic [7:0]  alu_accum;
  logic        alu_clk;
  logic [7:0]  alu_out;
  logic        alu_zero;
  logic [7:0]  accum;
  logic        result_valid;
  logic        halted;
  logic        illegal;
  logic [15:0] retired_cnt;

  logic [7:0]  alu_out_q = 8'h00;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_operand(instr_operand), .resume(resume),
    .alu_opcode(alu_opcode), .alu_data(alu_data), .alu_accum(alu_accum),
    .alu_clk(alu_clk), .alu_out(alu_out), .alu_zero(alu_zero),
    .accum(accum), .result_valid(result_valid), .halted(halted),
    .illegal(illegal), .retired_cnt(retired_cnt)
  );

  // Behavioural ALU: registers its result on the alu_clk strobe.
  always @(posedge alu_clk) begin
    case (alu_opcode)
      2'b00: alu_out_q <= alu_accum;
      2'b01: alu_out_q <= alu_accum + 8'd1;
      2'b10: alu_out_q <= alu_accum - 8'd1;
      default: alu_out_q <= alu_accum + alu_data;
    endcase
  end
  assign alu_out  = alu_out_q;
  assign alu_zero = (alu_accum == 8'h00);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_accum"},   32'(accum), 32'h00);
    check({tag, "_opcode"},  32'(alu_opcode), 32'h0);
    check({tag, "_data"},    32'(alu_data), 32'h00);
    check({tag, "_aluclk"},  32'(alu_clk), 32'h0);
    check({tag, "_rv"},      32'(result_valid), 32'h0);
    check({tag, "_halted"},  32'(halted), 32'h0);
    check({tag, "_illegal"}, 32'(illegal), 32'h0);
    check({tag, "_retired"}, 32'(retired_cnt), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    instr_valid = 1'b0;
    resume      = 1'b0;
    reset       = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Presents one instruction; returns 1ns after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [7:0] opr);
    int budget;
    budget = 0;
    @(negedge clk);
    instr_valid   = 1'b1;
    instr_op      = op;
    instr_operand = opr;
    while (!instr_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!instr_ready) check("send_timeout", 32'(instr_ready), 32'h1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  // ALU op: alu_clk high only in T+1, result_valid only in T+4, accum written then.
  task automatic alu_op(input string tag, input logic [2:0] op, input logic [7:0] opr,
                        input logic [7:0] exp);
    logic [3:0] clk_seq;
    logic [3:0] rv_seq;
    send(op, opr);
    for (int i = 0; i < 4; i++) begin
      clk_seq[3-i] = alu_clk;
      rv_seq[3-i]  = result_valid;
      if (i < 3) begin
        @(posedge clk);
        #1;
      end
    end
    check({tag, "_aluclk_seq"}, 32'(clk_seq), 32'b1000);
    check({tag, "_rv_seq"},     32'(rv_seq),  32'b0001);
    check({tag, "_accum"},      32'(accum),   32'(exp));
  endtask

  initial begin
    int hc;
    int na;
    int nr;
    int acc_cyc[2];
    logic [7:0] rvals[2];

    // Power-on reset
    #2 reset = 1'b0;
    #3;
    check_reset_state("por");
    check("por_ready", 32'(instr_ready), 32'h1);
    #10 reset = 1'b1;
    @(negedge clk);

    // Reset during WAIT of an ADD aborts it with no writeback
    send(OP_LDA, 8'h05);
    send(OP_ADD, 8'h03);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_reset_state("midadd");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("midadd_rv_hold", 32'(result_valid), 32'h0);
    check("midadd_accum_hold", 32'(accum), 32'h00);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midadd_ready_after", 32'(instr_ready), 32'h1);

    // LDA / ADD / INC / DEC
    send(OP_LDA, 8'h05);
    check("lda5_accum", 32'(accum), 32'h05);
    check("lda5_rv", 32'(result_valid), 32'h1);
    alu_op("add3", OP_ADD, 8'h03, 8'h08);
    alu_op("inc", OP_INC, 8'h00, 8'h09);
    alu_op("dec", OP_DEC, 8'h00, 8'h08);
    check("seq_retired", 32'(retired_cnt), 32'd4);

    // Wrap to zero, then SKZ
    do_reset();
    send(OP_LDA, 8'hFF);
    alu_op("incwrap", OP_INC, 8'h00, 8'h00);
    check("incwrap_zero", 32'(alu_zero), 32'h1);
    send(OP_SKZ, 8'h00);
    send(OP_LDA, 8'h11);
    check("skip_rv", 32'(result_valid), 32'h0);
    check("skip_accum", 32'(accum), 32'h00);
    check("skip_retired", 32'(retired_cnt), 32'd4);
    send(OP_LDA, 8'h01);
    send(OP_SKZ, 8'h00);
    send(OP_LDA, 8'h22);
    check("noskip_accum", 32'(accum), 32'h22);
    check("noskip_rv", 32'(result_valid), 32'h1);

    // DEC from zero wraps to all-ones
    do_reset();
    alu_op("decwrap", OP_DEC, 8'h00, 8'hFF);

    // HLT with a queued instruction
    do_reset();
    @(negedge clk);
    instr_valid   = 1'b1;
    instr_op      = OP_HLT;
    instr_operand = 8'h00;
    @(posedge clk);
    #1;
    instr_op      = OP_LDA;
    instr_operand = 8'h33;
    hc = 0;
    for (int i = 0; i < 10; i++) begin
      if (halted && !instr_ready) hc++;
      @(posedge clk);
      #1;
    end
    check("halt_cycles", 32'(hc), 32'd10);
    check("halt_retired", 32'(retired_cnt), 32'd0);
    @(negedge clk);
    resume = 1'b1;
    @(posedge clk);
    #1;
    resume = 1'b0;
    check("resume_ready", 32'(instr_ready), 32'h1);
    check("resume_halted", 32'(halted), 32'h0);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    check("queued_accum", 32'(accum), 32'h33);
    check("queued_rv", 32'(result_valid), 32'h1);
    check("queued_retired", 32'(retired_cnt), 32'd1);

    // Illegal op is sticky
    do_reset();
    send(OP_LDA, 8'h44);
    send(OP_ILL, 8'h00);
    check("ill_flag", 32'(illegal), 32'h1);
    check("ill_accum", 32'(accum), 32'h44);
    check("ill_retired", 32'(retired_cnt), 32'd2);
    send(OP_LDA, 8'h00);
    check("ill_sticky", 32'(illegal), 32'h1);
    check("ill_lda_accum", 32'(accum), 32'h00);
    check("ill_lda_retired", 32'(retired_cnt), 32'd3);
    send(OP_NOP, 8'h00);
    check("nop_retired", 32'(retired_cnt), 32'd4);

    // Back-to-back ADDs with instr_valid held high
    do_reset();
    send(OP_LDA, 8'h00);
    @(posedge clk);
    #1;
    na = 0;
    nr = 0;
    acc_cyc[0] = -1;
    acc_cyc[1] = -1;
    rvals[0] = 8'hxx;
    rvals[1] = 8'hxx;
    @(negedge clk);
    instr_valid   = 1'b1;
    instr_op      = OP_ADD;
    instr_operand = 8'h80;
    for (int c = 0; c < 14; c++) begin
      if (result_valid && nr < 2) begin
        rvals[nr] = accum;
        nr++;
      end
      if (instr_ready) begin
        if (na < 2) begin
          acc_cyc[na] = c;
          na++;
        end else begin
          instr_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    check("b2b_accepts", 32'(na), 32'd2);
    check("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
    check("b2b_results", 32'(nr), 32'd2);
    check("b2b_first", 32'(rvals[0]), 32'h80);
    check("b2b_second", 32'(rvals[1]), 32'h00);
    check("b2b_retired", 32'(retired_cnt), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", n_checks, n_pass);
    $fatal(1, "watchdog");
  end

endmodule
